// File: rtl/apb_i2c_bridge_pkg.sv
// Shared types and constants for the APB-to-I2C command bridge.
package apb_i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int TIMEOUT_CYC_DEFAULT = 1023;

    // The watchdog must be able to hold TIMEOUT_CYC itself.
    function automatic int wd_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/apb_i2c_bridge_if.sv
// Bus bundle: APB3 completer signals plus the command/completion set of the I2C master.
interface apb_i2c_bridge_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    logic       m_ce;
    logic       m_wren;
    logic       m_rden;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic       m_error;
    logic       m_done;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr,
        output m_ce, m_wren, m_rden, m_addr, m_wdata,
        input  m_rdata, m_error, m_done
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr,
        input  m_ce, m_wren, m_rden, m_addr, m_wdata,
        output m_rdata, m_error, m_done
    );
endinterface

// File: rtl/apb_i2c_bridge_watchdog.sv
// Saturating up-counter with clear, load and enable; tc flags that LIMIT has been reached.
module i2c_watchdog #(
    parameter int LIMIT = 1023,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         tc
);

    logic [W-1:0] count;

    assign tc = (count == W'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_i2c_bridge.sv
// APB3 completer that issues one I2C master command per access and waits for done or timeout.
//   state | meaning
//   IDLE  | latch setup phase, start on access phase
//   ISSUE | m_ce strobe high, watchdog cleared
//   WAIT  | wait for m_done or watchdog terminal count
//   RESP  | pready pulse with prdata/pslverr
module apb_i2c_bridge
    import apb_i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    apb_i2c_bridge_if.slave  bus
);

    localparam int WD_W = wd_width(TIMEOUT_CYC);

    state_t state;
    logic   dir;
    logic   wd_clear;
    logic   wd_en;
    logic   wd_tc;

    assign wd_clear = (state == ISSUE);
    assign wd_en    = (state == WAIT) && !bus.m_done;

    i2c_watchdog #(
        .LIMIT (TIMEOUT_CYC),
        .W     (WD_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .load     (1'b0),
        .load_val ({WD_W{1'b0}}),
        .enable   (wd_en),
        .tc       (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dir         <= 1'b0;
            bus.prdata  <= '0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.m_ce    <= 1'b0;
            bus.m_wren  <= 1'b0;
            bus.m_rden  <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
        end else begin
            bus.m_ce    <= 1'b0;
            bus.m_wren  <= 1'b0;
            bus.m_rden  <= 1'b0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
            case (state)
                IDLE: begin
                    if (bus.psel && !bus.penable) begin
                        bus.m_addr  <= bus.paddr;
                        bus.m_wdata <= bus.pwdata;
                        dir         <= bus.pwrite;
                    end else if (bus.psel && bus.penable) begin
                        state      <= ISSUE;
                        bus.m_ce   <= 1'b1;
                        bus.m_wren <= dir;
                        bus.m_rden <= !dir;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // m_done takes priority over a coincident terminal count
                    if (bus.m_done) begin
                        state       <= RESP;
                        bus.pready  <= 1'b1;
                        bus.prdata  <= dir ? 8'h00 : bus.m_rdata;
                        bus.pslverr <= bus.m_error;
                    end else if (wd_tc) begin
                        state       <= RESP;
                        bus.pready  <= 1'b1;
                        bus.pslverr <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_bridge.sv
// Directed bench for apb_i2c_bridge with TIMEOUT_CYC=8 and a hand-driven I2C master.
module tb_apb_i2c_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    apb_i2c_bridge_if bus();

    apb_i2c_bridge #(.TIMEOUT_CYC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int         ce_at, rdy_at, ce_n, c_first;
    logic       wren_s, rden_s, err_s;
    logic [7:0] addr_s, wdata_s, prd_s;
    logic       seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // lat = cycles from m_ce to m_done; 0 means the master never answers
    task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input int lat, input logic [7:0] rd, input bit er);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
        @(negedge clk);
        bus.penable = 1'b1;
        ce_at = -1; rdy_at = -1; ce_n = 0;
        for (int i = 0; i < 40 && rdy_at < 0; i++) begin
            @(negedge clk);
            bus.m_done = 1'b0;
            if (bus.m_ce) begin
                ce_n++; ce_at = cyc;
                wren_s = bus.m_wren; rden_s = bus.m_rden;
                addr_s = bus.m_addr; wdata_s = bus.m_wdata;
            end
            if (bus.pready) begin
                rdy_at = cyc; prd_s = bus.prdata; err_s = bus.pslverr;
            end else if (lat > 0 && ce_at >= 0 && cyc == ce_at + lat) begin
                bus.m_done = 1'b1; bus.m_rdata = rd; bus.m_error = er;
            end
        end
    endtask

    task automatic after_resp(input string tag);
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0;
        chk({tag, "_pready_width"}, bus.pready, 1'b0);
        chk({tag, "_prdata_clr"}, bus.prdata, 8'h00);
    endtask

    task automatic quiet(input string tag, input int n);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.m_done = 1'b0;
            if (bus.pready || bus.m_ce) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    function automatic logic [31:0] outs_zero();
        return {31'd0, (bus.prdata == 0) && !bus.pready && !bus.pslverr && !bus.m_ce &&
                !bus.m_wren && !bus.m_rden && (bus.m_addr == 0) && (bus.m_wdata == 0)};
    endfunction

    initial begin
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
        bus.m_rdata = 0; bus.m_error = 0; bus.m_done = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_zero(), 1);
        reset = 1'b0;
        @(negedge clk);

        access(1'b1, 8'h12, 8'hA5, 2, 8'h77, 1'b0);
        chk("wr_ce_count", ce_n, 1);
        chk("wr_wren", wren_s, 1'b1);
        chk("wr_rden", rden_s, 1'b0);
        chk("wr_addr", addr_s, 8'h12);
        chk("wr_wdata", wdata_s, 8'hA5);
        chk("wr_latency", rdy_at - ce_at, 3);
        chk("wr_pslverr", err_s, 1'b0);
        chk("wr_prdata", prd_s, 8'h00);
        after_resp("wr");

        access(1'b0, 8'h40, 8'h00, 1, 8'h3C, 1'b0);
        chk("rd_rden", rden_s, 1'b1);
        chk("rd_wren", wren_s, 1'b0);
        chk("rd_addr", addr_s, 8'h40);
        chk("rd_latency_min", rdy_at - ce_at, 2);
        chk("rd_prdata", prd_s, 8'h3C);
        chk("rd_pslverr", err_s, 1'b0);
        after_resp("rd");

        access(1'b0, 8'h41, 8'h00, 3, 8'hFF, 1'b1);
        chk("nack_pslverr", err_s, 1'b1);
        chk("nack_prdata", prd_s, 8'hFF);
        chk("nack_latency", rdy_at - ce_at, 4);
        after_resp("nack");

        access(1'b0, 8'h50, 8'h00, 0, 8'h00, 1'b0);
        chk("to_latency", rdy_at - ce_at, 10);
        chk("to_pslverr", err_s, 1'b1);
        chk("to_prdata", prd_s, 8'h00);
        after_resp("to");
        bus.m_done = 1'b1; bus.m_error = 1'b1; bus.m_rdata = 8'hEE;
        quiet("to_late_done_ignored", 5);

        access(1'b0, 8'h51, 8'h00, 9, 8'h5A, 1'b0);
        chk("race_latency", rdy_at - ce_at, 10);
        chk("race_pslverr", err_s, 1'b0);
        chk("race_prdata", prd_s, 8'h5A);
        after_resp("race");

        access(1'b1, 8'h60, 8'h11, 1, 8'h00, 1'b0);
        c_first = ce_at;
        access(1'b1, 8'h61, 8'h22, 1, 8'h00, 1'b0);
        chk("b2b_ce_spacing", ce_at - c_first, 5);
        chk("b2b_addr", addr_s, 8'h61);
        chk("b2b_wdata", wdata_s, 8'h22);
        after_resp("b2b");

        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h55;
        @(negedge clk);
        bus.penable = 1'b1;
        @(negedge clk);
        chk("rst_ce_seen", bus.m_ce, 1'b1);
        @(negedge clk);
        reset = 1'b1; bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        chk("rst_outputs_zero", outs_zero(), 1);
        reset = 1'b0;
        quiet("rst_no_pready", 12);

        access(1'b0, 8'h33, 8'h00, 1, 8'h81, 1'b0);
        chk("post_rst_prdata", prd_s, 8'h81);
        chk("post_rst_pslverr", err_s, 1'b0);
        chk("post_rst_addr", addr_s, 8'h33);
        after_resp("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
